// File: rtl/fpu_issue_seq.sv
// rtl/fpu_issue_seq.sv - blocking single-issue sequencer for the double-precision FPU units
// Accepts one op, pulses the unit start, waits the op's fixed latency, then holds a writeback.
module fpu_issue_seq #(
  parameter int XLEN     = 64,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            unit_start,
  output logic [2:0]      unit_op,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  input  logic [XLEN-1:0] unit_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       first;
  logic       accept;
  logic       capture;

  // Counter is loaded with LAT-1 so that EXEC lasts exactly LAT cycles.
  function automatic logic [4:0] lat_m1(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: return 5'(LAT_ADD - 1);
      3'b010:         return 5'(LAT_MUL - 1);
      3'b011:         return 5'(LAT_DIV - 1);
      3'b100:         return 5'(LAT_SQRT - 1);
      default:        return 5'(LAT_CVT - 1);
    endcase
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    in_ready   = (state == IDLE) && !flush && !rst;
    unit_start = (state == EXEC) && first && !flush;
    wb_valid   = (state == WB) && !flush;
    busy       = (state != IDLE);
    if (rst || flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            accept = 1'b1;
            if (in_op == OP_ILLEGAL) begin
              state_nxt = WB;
            end else begin
              state_nxt = EXEC;
              cnt_nxt   = lat_m1(in_op);
            end
          end
        end
        EXEC: begin
          if (cnt == 5'd0) begin
            capture   = 1'b1;
            state_nxt = WB;
          end else begin
            cnt_nxt = cnt - 5'd1;
          end
        end
        WB: begin
          if (wb_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      first      <= 1'b0;
      unit_op    <= 3'd0;
      unit_a     <= '0;
      unit_b     <= '0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      wb_illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      first <= accept && (in_op != OP_ILLEGAL);
      if (accept) begin
        wb_rd <= in_rd;
        // Illegal ops never reach the unit bus; they retire with a zero result.
        if (in_op == OP_ILLEGAL) begin
          wb_data    <= '0;
          wb_illegal <= 1'b1;
        end else begin
          unit_op <= in_op;
          unit_a  <= in_rs1;
          unit_b  <= in_rs2;
        end
      end
      if (capture) begin
        wb_data    <= unit_result;
        wb_illegal <= 1'b0;
      end
    end
  end

endmodule
